// File: rtl/fixed_point_subtract_sequencer_if.sv
// Operand request / result handshake bundle for the multi-precision subtract
// sequencer. The requester drives through master, the sequencer sits on slave.
interface fixed_point_subtract_sequencer_if #(
  parameter int N     = 32,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_borrow;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_overflow;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_b, in_borrow, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_borrow, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_overflow, out_zero
  );
endinterface

// File: rtl/fixed_point_subtract_sequencer.sv
// Multi-precision subtract controller: walks a WORDS*N-bit subtraction through
// one shared N-bit subtract datapath, least-significant word first, carrying
// the borrow between words, then presents difference and flags until taken.

// Shared N-bit subtractor: a - b - borrow_in, with borrow out.
module fixed_point_subtract_datapath #(
  parameter int    N         = 32,
  parameter string ALGORITHM = "RippleCarrySubtraction"
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);
  generate
    if (ALGORITHM == "RippleCarrySubtraction") begin : g_ripple
      logic w_br;
      // Bit-serial borrow chain, one full subtractor per bit.
      always_comb begin
        // NOTE: every variable written here gets a value before any branch or
        // loop touches it, so no path can leave it holding an old value (latch).
        w_br   = i_borrow;
        o_diff = '0;
        for (int i = 0; i < N; i++) begin
          o_diff[i] = i_a[i] ^ i_b[i] ^ w_br;
          w_br      = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_br);
        end
        o_borrow = w_br;
      end
    end else begin : g_behavioural
      logic [N:0] w_full;
      assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{N{1'b0}}, i_borrow};
      assign o_diff   = w_full[N-1:0];
      assign o_borrow = w_full[N];
    end
  endgenerate
endmodule

module fixed_point_subtract_sequencer #(
  parameter int    N         = 32,
  parameter int    WORDS     = 4,
  parameter string ALGORITHM = "RippleCarrySubtraction"
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic busy,
  fixed_point_subtract_sequencer_if.slave bus
);
  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_diff;
  logic          r_brw;
  logic          r_overflow;
  logic          r_zero;

  logic [N-1:0]  w_a_word;
  logic [N-1:0]  w_b_word;
  logic [N-1:0]  w_d;
  logic          w_bout;

  assign w_a_word = r_a[r_k*N +: N];
  assign w_b_word = r_b[r_k*N +: N];

  fixed_point_subtract_datapath #(
    .N         (N),
    .ALGORITHM (ALGORITHM)
  ) u_datapath (
    .i_a      (w_a_word),
    .i_b      (w_b_word),
    .i_borrow (r_brw),
    .o_diff   (w_d),
    .o_borrow (w_bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; clear overrides every transition.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_next = RUN;
      RUN:     if (r_k == K_LAST) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear) w_next = IDLE;
  end

  // Operand capture, word-serial difference accumulation and flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are plain registers, not a memory array, so they take a
      // reset value and the outputs are defined straight out of reset.
      r_k        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_diff     <= '0;
      r_brw      <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (clear) begin
      r_k <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_brw <= bus.in_borrow;
            r_k   <= '0;
          end
        end
        RUN: begin
          r_diff[r_k*N +: N] <= w_d;
          r_brw              <= w_bout;
          r_k                <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            // Top word: sign bits of a, b and the fresh difference word.
            r_overflow <= (r_a[W-1] != r_b[W-1]) && (w_d[N-1] != r_a[W-1]);
            r_zero     <= (r_diff[W-N-1:0] == '0) && (w_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.out_valid    = (r_state == DONE);
  assign busy             = (r_state != IDLE);
  assign bus.out_diff     = r_diff;
  assign bus.out_borrow   = r_brw;
  assign bus.out_overflow = r_overflow;
  assign bus.out_zero     = r_zero;
endmodule

// File: tb/tb_fixed_point_subtract_sequencer.sv
// Scoreboard bench for the multi-precision subtract sequencer: expectations are
// pushed when a request is accepted and popped when a result is handed over.
module tb_fixed_point_subtract_sequencer;
  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         brw;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fixed_point_subtract_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  fixed_point_subtract_sequencer #(
    .N         (N),
    .WORDS     (WORDS),
    .ALGORITHM ("RippleCarrySubtraction")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // Reference: full-width subtract in W+1 bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = full[W-1:0];
    e.brw  = full[W];
    e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    e.zero = (e.diff == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a request and hold it until accepted; returns at the falling edge
  // right after the accepting rising edge, with in_valid dropped.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_borrow = bin;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", bus.in_ready);
    end
    @(posedge clk);
    sb.push_back(model(a, b, bin));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = rnd_word();
    bus.in_b     = rnd_word();
  endtask

  // Wait for out_valid (counted in falling edges since the accepting edge;
  // the first one after acceptance counts as 1, so DONE shows at WORDS+1),
  // compare against the scoreboard head, then take the result.
  task automatic collect_result(input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%0b want 1", bus.out_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL latency: got %0d want %0d", lat, exp_lat);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got result with no expectation");
      return;
    end
    e = sb.pop_front();
    if (bus.out_diff !== e.diff) begin
      errors++;
      $display("FAIL diff: got %h want %h", bus.out_diff, e.diff);
    end
    checks++;
    if (bus.out_borrow !== e.brw) begin
      errors++;
      $display("FAIL borrow: got %0b want %0b", bus.out_borrow, e.brw);
    end
    checks++;
    if (bus.out_overflow !== e.ovf) begin
      errors++;
      $display("FAIL overflow: got %0b want %0b", bus.out_overflow, e.ovf);
    end
    checks++;
    if (bus.out_zero !== e.zero) begin
      errors++;
      $display("FAIL zero: got %0b want %0b", bus.out_zero, e.zero);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_ready: in_ready=%0b busy=%0b want 0 1", bus.in_ready, busy);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    send_op(a, b, bin);
    collect_result(WORDS + 1);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_diff !== '0 || bus.out_borrow !== 1'b0 ||
        bus.out_overflow !== 1'b0 || bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy=%0b busy=%0b vld=%0b diff=%h brw=%0b ovf=%0b zero=%0b want 1 0 0 0 0 0 0",
               tag, bus.in_ready, busy, bus.out_valid, bus.out_diff,
               bus.out_borrow, bus.out_overflow, bus.out_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_directed();
    logic [W-1:0] p5a;
    logic [W-1:0] ones;
    p5a  = {16{8'h5A}};
    ones = '1;
    do_op(128'd1, 128'd0, 1'b0);
    do_op(p5a, p5a, 1'b0);
    do_op(128'd0, 128'd1, 1'b0);
    do_op(128'd0, 128'd0, 1'b1);
    do_op(128'h1_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0);
    do_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0);
    do_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, ones, 1'b0);
    // Independent spot check of one constant against the last directed result.
    do_op(128'd1, 128'd0, 1'b0);
    checks++;
    if (bus.out_diff !== 128'd1) begin
      errors++;
      $display("FAIL one_minus_zero_hold: got %h want 1", bus.out_diff);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_op(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a2;
    logic [W-1:0] b2;
    exp_t         e;
    int           lat;
    a2 = 128'hDEAD_BEEF_0000_0001_1234_5678_9ABC_DEF0;
    b2 = 128'h0000_0001_FFFF_FFFF_0000_0000_9ABC_DEF1;
    send_op(128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'd3, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid  = 1'b1;
    bus.in_a      = a2;
    bus.in_b      = b2;
    bus.in_borrow = 1'b1;
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_diff !== e.diff ||
          bus.out_borrow !== e.brw || bus.out_overflow !== e.ovf || bus.out_zero !== e.zero) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: vld=%0b rdy=%0b diff=%h want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_diff, e.diff);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: vld=%0b rdy=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    sb.push_back(model(a2, b2, 1'b1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = rnd_word();
    collect_result(WORDS + 1);
  endtask

  task automatic test_clear_run();
    int seen;
    send_op(rnd_word(), rnd_word(), 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_run: busy=%0b rdy=%0b vld=%0b want 0 1 0", busy, bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL clear_no_result: out_valid cycles=%0d want 0", seen);
    end
    do_op(128'd5, 128'd3, 1'b0);
  endtask

  task automatic test_clear_handshake();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 128'd9;
    bus.in_b     = 128'd4;
    clear        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_accept: busy=%0b rdy=%0b want 0 1", busy, bus.in_ready);
    end
    send_op(128'd9, 128'd4, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bus.out_ready = 1'b1;
    clear         = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_release: vld=%0b rdy=%0b busy=%0b want 0 1 0",
               bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_reset_done();
    int lat;
    int seen;
    send_op(rnd_word(), rnd_word(), 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_reset_values("reset_mid_done");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_result: out_valid cycles=%0d want 0", seen);
    end
    do_op(128'd5, 128'd3, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_borrow = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_clear_run();
    test_clear_handshake();
    test_reset_done();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fixed_point_subtract_sequencer.md
# fixed_point_subtract_sequencer

Multi-precision subtract controller. Accepts two WORDS×N-bit operands over a valid/ready handshake and sequences a single N-bit subtract datapath word by word, least-significant word first, propagating the borrow between words. Returns the wide difference plus borrow, signed-overflow and zero flags on a valid/ready output. It sits between wide-arithmetic requesters and the shared N-bit fixed-point subtract datapath, so wide subtraction reuses one N-bit subtractor.

## Interface
- N, 32, datapath word width in bits (≥2).
- WORDS, 4, number of N-bit words per operand (≥2); operand width W = N*WORDS.
- ALGORITHM, "RippleCarrySubtraction", passed unchanged to the internal N-bit subtract datapath.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns to IDLE and discards any in-flight operation.
- in_valid  input  1  request operands valid.
- in_ready  output  1  high only in IDLE.
- in_a  input  W  minuend.
- in_b  input  W  subtrahend.
- in_borrow  input  1  initial borrow into word 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_diff  output  W  in_a − in_b − in_borrow, mod 2^W.
- out_borrow  output  1  borrow out of the top word; 1 when the unsigned result is negative.
- out_overflow  output  1  two's-complement overflow of the W-bit signed subtract.
- out_zero  output  1  out_diff == 0.
- busy  output  1  state != IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register in_a, in_b and in_borrow, clear word index k to 0, and go to RUN.
- RUN: each cycle compute d = a[k] − b[k] − brw on word k (bits k*N+N−1 : k*N). The next borrow is 1 when a[k] < b[k] + brw, evaluated unsigned in N+1 bits. Write d into diff word k, register the borrow, and increment k. When k == WORDS−1, go to DONE.
- DONE: out_valid=1. out_diff and the flags hold stable until the out_valid && out_ready handshake, which returns the block to IDLE.
- out_overflow = (a[W−1] != b[W−1]) && (diff[W−1] != a[W−1]), evaluated on the top word. It ignores in_borrow's effect on the sign only insofar as the formula above is defined.
- out_zero is computed over the full registered out_diff.
- Operand registers do not change outside IDLE acceptance. in_a and in_b may change freely once accepted.
- clear has priority over every transition. On the next edge: state=IDLE, k=0, out_valid=0. out_diff and the flags keep their previous values, which are don't-care.
- rst_n low, asynchronous: state=IDLE, k=0, borrow=0, all result registers 0. Reset is honoured mid-RUN and mid-DONE with no output handshake.
- WORDS is a fixed compile-time value; there is no variable-length operation.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, out_diff=0, out_borrow=0, out_overflow=0, out_zero=0.
- Accept at edge E0. RUN covers cycles E0..E_WORDS, with word k registered at E_{k+1}. DONE is entered at E_WORDS, so out_valid rises WORDS cycles after acceptance.
- in_ready and out_valid are decoded from registered state and never both high. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Minimum initiation interval is WORDS+2 cycles: WORDS in RUN, at least 1 in DONE, and 1 in IDLE. The block never accepts a request in the same cycle as an output handshake.
- Output backpressure: DONE persists indefinitely while out_ready=0, with all outputs stable.
- clear asserted in the same cycle as an input or output handshake: clear wins. The input is not captured, or the result is dropped, and the block is in IDLE after the edge.

## Test plan
- Subtract 1 − 0 (N=32, WORDS=4, in_borrow=0) → after 4 cycles diff=1, borrow=0, overflow=0, zero=0. Then 0x5A5A…5A − the same value → diff=0, zero=1.
- Subtract 0 − 1 → diff=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, borrow=1, overflow=0. Also 0 − 0 with in_borrow=1 → the same result.
- Borrow chain: a=0x1_0000_0000_0000_0000_0000_0000, b=1 → diff=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, borrow=0.
- Signed overflow: a=0x8000_0000_0000_0000_0000_0000_0000_0000, b=1 → diff=0x7FFF…FFFF, overflow=1, borrow=0. Also a=0x7FFF…FFFF, b=0xFFFF…FFFF (−1) → diff=0x8000…0000, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with a second in_valid pending → outputs stable, in_ready=0. Release out_ready → handshake, then in_ready=1 one cycle later and the second operation completes correctly.
- Abort: pulse clear during RUN at k=2, and separately drop rst_n mid-DONE → out_valid never asserts for the aborted operation, reset values appear, and the next request (e.g. 5 − 3 → 2) completes normally.
